// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and defaults for the data-memory arbiter
//
// Contents:
//   arb_state_t     owner of the access issued in the previous cycle
//   DW_DEF, AW_DEF  default data width and word-address width
//   STARVE_MAX_DEF  default number of denied debug cycles before debug is forced
//   STARVE_W        width of the starvation counter (covers STARVE_MAX up to 15)

package arm_pkg;

    localparam int DW_DEF         = 32;
    localparam int AW_DEF         = 6;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CORE_RD = 2'd1,
        ST_DBG_RD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating counter of consecutive denied debug cycles
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   inc       debug requested but was not granted this cycle
//   clr       debug was granted or is not requesting; clear wins over inc
//   at_max    counter has reached MAX, so debug must win the next conflict

module arb_starve_ctr
    import arm_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF,
    parameter int W   = STARVE_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter in front of a single-port synchronous data memory
//
// Optional feature macro: DMEM_ARB_STATS_EN (conflict-cycle statistics counter).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   core_*                    core load/store port (byte address, stall, load response, misalign pulse)
//   dbg_*                     debug port (word address, read response)
//   core_halted               core stopped; debug always wins a conflict
//   mem_*                     single-port memory interface, read data one cycle after issue
//   stat_conflicts            cycles with both requesters active (0 unless the macro is defined)

module dmem_arbiter
    import arm_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW+1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_misalign,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          core_halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_conflicts
);

    arb_state_t    state;
    logic          starve_at_max;
    logic          dbg_wins;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    // Debug takes a conflict only when the core is halted or debug has been
    // starved long enough; a lone requester always wins.
    assign dbg_wins   = core_halted | starve_at_max;
    assign dbg_gnt    = dbg_req & (~core_req | dbg_wins);
    assign core_gnt   = core_req & ~dbg_gnt;
    assign core_stall = core_req & ~core_gnt;

    assign mem_en    = core_gnt | dbg_gnt;
    assign mem_we    = dbg_gnt ? dbg_we    : (core_gnt & core_we);
    assign mem_addr  = dbg_gnt ? dbg_addr  : (core_gnt ? core_addr[AW+1:2] : '0);
    assign mem_wdata = dbg_gnt ? dbg_wdata : (core_gnt ? core_wdata : '0);

    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (STARVE_W)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (dbg_req & ~dbg_gnt),
        .clr    (dbg_gnt | ~dbg_req),
        .at_max (starve_at_max)
    );

    // State tracks who owns the read data arriving this cycle. It is
    // re-evaluated every cycle so a new access can issue while the previous
    // read's data is being returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            core_rvalid   <= 1'b0;
            dbg_rvalid    <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            core_misalign <= 1'b0;
        end else begin
            case (state)
                ST_CORE_RD: core_rdata_q <= mem_rdata;
                ST_DBG_RD:  dbg_rdata_q  <= mem_rdata;
                default:    ;
            endcase

            if (core_gnt && !core_we) begin
                state <= ST_CORE_RD;
            end else if (dbg_gnt && !dbg_we) begin
                state <= ST_DBG_RD;
            end else begin
                state <= ST_IDLE;
            end

            core_rvalid   <= core_gnt & ~core_we;
            dbg_rvalid    <= dbg_gnt & ~dbg_we;
            core_misalign <= core_gnt & (|core_addr[1:0]);
        end
    end

    // The memory's read data is only valid in the response cycle, so it is
    // passed straight through then and held from the register afterwards.
    assign core_rdata = (state == ST_CORE_RD) ? mem_rdata : core_rdata_q;
    assign dbg_rdata  = (state == ST_DBG_RD)  ? mem_rdata : dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflicts <= 16'd0;
        end else if (core_req && dbg_req && (stat_conflicts != 16'hFFFF)) begin
            stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`else
    assign stat_conflicts = 16'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the ARM core load/store port and a debug port.
- The debug port is used for memory preload, memory dump and inspection of a halted core.
- One memory access issues per cycle; read data returns one cycle later.
- The core has priority, bounded by a starvation guard that forces a debug grant.
- Sits between the core's MEM stage, the debug controller and the data memory.

Parameters:
- DW, 32, data width in bits
- AW, 6, memory word-address width (64 words)
- STARVE_MAX, 4, consecutive denied debug cycles before debug is forced to win (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core access request; held until granted
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW+2  byte address; bits [1:0] ignored for word select
- core_wdata  in  DW  store data
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req && !core_gnt; freezes the pipeline
- core_rvalid  out  1  load data valid; one cycle after a load grant
- core_rdata  out  DW  load data
- core_misalign  out  1  registered pulse, one cycle after a granted access with core_addr[1:0] != 0
- dbg_req  in  1  debug request; held until granted
- dbg_we  in  1  debug write
- dbg_addr  in  AW  word address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug access issued this cycle
- dbg_rvalid  out  1  debug read data valid, one cycle after a read grant
- dbg_rdata  out  DW  debug read data
- core_halted  in  1  core stopped (pc past program end); debug always wins
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en && !mem_we
- stat_conflicts  out  16  cycles in which both requesters were active (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. State is IDLE. The starvation counter is 0.
- Grant logic is combinational within a cycle:
  - if only one requester is active, it is granted;
  - if both are active, debug wins when core_halted = 1 or starve_cnt == STARVE_MAX; otherwise core wins;
  - if none is active, nothing is granted and mem_en = 0.
- Memory mux:
  - mem_en = core_gnt | dbg_gnt.
  - mem_we, mem_addr and mem_wdata come from the granted requester.
  - The core's word address is core_addr[AW+1:2].
- Starvation counter (starve_cnt):
  - increments, saturating at STARVE_MAX, on each cycle with dbg_req && !dbg_gnt;
  - clears on dbg_gnt or !dbg_req.
- The FSM records the owner of the access issued in the previous cycle:
  - IDLE → CORE_RD on a core load grant;
  - IDLE → DBG_RD on a debug read grant;
  - writes and no-grant cycles → IDLE;
  - transitions are evaluated every cycle from any state. This allows back-to-back issue with no bubble.
- Response routing:
  - In CORE_RD: core_rvalid = 1 and core_rdata = mem_rdata.
  - In DBG_RD: dbg_rvalid = 1 and dbg_rdata = mem_rdata.
  - rdata outputs are registered and hold their last value otherwise.
  - Writes produce no rvalid.
- Same-address conflict: core and debug are never granted together, so no write-write race exists. A read issued the cycle after a write to the same address returns the new data; this is the memory's responsibility.
- core_stall is combinational, with no added latency.
- Changing req or addr while a request is stalled is illegal. The bench flags it; the RTL takes no action.
- Reset mid-access: an in-flight rvalid is dropped; the FSM goes to IDLE; the counter clears.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: stat_conflicts is a 16-bit saturating counter. It increments each cycle with core_req && dbg_req and clears on rst.
- Undefined: stat_conflicts is tied to 0 and no counter flops exist.

Decomposition:
- Shared package arm_pkg holds:
  - the FSM state encoding (IDLE=2'd0, CORE_RD=2'd1, DBG_RD=2'd2);
  - DW and AW defaults;
  - the STARVE_MAX default.
- One natural sub-module: arb_starve_ctr. It holds the saturating starvation counter with inputs inc, clr and output at_max.

Test Plan:
- Core load only, addr 0x10, mem word 4 = 0xDEADBEEF → core_gnt in cycle N; core_rvalid = 1 and core_rdata = 0xDEADBEEF in N+1; core_stall never asserts.
- Core and debug request together, core_halted = 0, core_req held continuously → core granted 4 cycles; cycle 5 dbg_gnt = 1 and core_stall = 1; counter cleared afterwards.
- core_halted = 1, debug reads words 0..63 back-to-back → 64 consecutive dbg_gnt; dbg_rvalid on each following cycle; data matches the preload file.
- Debug writes 0x12345678 to word 5, then core loads byte address 0x14 → core_rdata = 0x12345678.
- Core store to byte address 0x13 → core_misalign pulses one cycle later; mem_addr = 4.
- Reset asserted in the cycle after a core load grant → core_rvalid stays 0. With DMEM_ARB_STATS_EN defined, stat_conflicts counts exactly the overlapping-request cycles seen before the reset.
